// File: rtl/nrisc_pkg.sv
// Shared opcode, state and write-back encodings for the nRisc phase controller.
// Constants and helpers only; no timing and no flow control.
package nrisc_pkg;

  localparam logic [2:0] LI  = 3'b011;
  localparam logic [2:0] LD  = 3'b100;
  localparam logic [2:0] ST  = 3'b101;
  localparam logic [2:0] BEQ = 3'b110;
  localparam logic [2:0] BNZ = 3'b111;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_READ     = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_MEM_WAIT = 3'd4;
  localparam logic [2:0] S_WRITE    = 3'd5;
  localparam logic [2:0] S_HALT     = 3'd6;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;

  typedef struct packed {
    logic       ir_load;
    logic       rf_read;
    logic       alu_start;
    logic       mem_start;
    logic       mem_we;
    logic       rf_write;
    logic [1:0] wb_sel;
    logic       wb_r1;
    logic       pc_inc;
    logic       pc_branch;
    logic       busy;
  } ctl_t;

  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == LD) || (op == ST);
  endfunction

  function automatic logic writes_rf(input logic [2:0] op);
    return (op != ST) && (op != BNZ);
  endfunction

  function automatic logic [1:0] wb_src(input logic [2:0] op);
    if (op == LI) return WB_IMM;
    if (op == LD) return WB_MEM;
    return WB_ALU;
  endfunction

endpackage

// File: rtl/nrisc_timeout_counter.sv
// Counts data-memory wait cycles; load starts at 1, terminal flags LIMIT reached.
// Single-cycle update; no flow control, holds at the terminal value.
module nrisc_timeout_counter #(
  parameter int LIMIT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic load,
  input  logic inc,
  output logic terminal
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= W'(1);
    end else if (inc && !terminal) begin
      count <= count + W'(1);
    end
  end

  assign terminal = (count == W'(LIMIT));

endmodule

// File: rtl/nrisc_phase_controller.sv
// Multi-cycle nRisc sequencer: registered one-cycle strobes per phase of each instruction.
// Latency ALU/BEQ 4, LI 2, BNZ 3, LD/ST 3+n cycles; memory stalls via mem_ready with timeout to HALT.
module nrisc_phase_controller
  import nrisc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic [2:0]       instruction,
  input  logic             r1_zero,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             rf_read,
  output logic             alu_start,
  output logic             mem_start,
  output logic             mem_we,
  output logic             rf_write,
  output logic [1:0]       wb_sel,
  output logic             wb_r1,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  logic [2:0]       state;
  logic [2:0]       state_d;
  logic [2:0]       op_q;
  logic [2:0]       op_d;
  ctl_t             ctl_q;
  ctl_t             ctl_d;
  logic             fault_q;
  logic [CNT_W-1:0] retired_q;

  logic to_clear;
  logic to_load;
  logic to_inc;
  logic to_terminal;

  // The opcode is live during FETCH and held from the IR load onwards.
  assign op_d = (state == S_FETCH) ? instruction : op_q;

  always_comb begin
    state_d  = state;
    to_clear = 1'b0;
    to_load  = 1'b0;
    to_inc   = 1'b0;
    case (state)
      S_IDLE:     if (run) state_d = S_FETCH;
      S_FETCH:    state_d = (instruction == LI) ? S_WRITE : S_READ;
      S_READ: begin
        if (is_mem_op(op_q)) begin
          state_d = S_MEM_WAIT;
          to_load = 1'b1;
        end else if (op_q == BNZ) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:     state_d = S_WRITE;
      S_MEM_WAIT: begin
        // A completion on the terminal cycle still wins over the timeout.
        if (mem_ready) begin
          state_d  = S_WRITE;
          to_clear = 1'b1;
        end else if (to_terminal) begin
          state_d  = S_HALT;
          to_clear = 1'b1;
        end else begin
          to_inc = 1'b1;
        end
      end
      S_WRITE:    state_d = run ? S_FETCH : S_IDLE;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctl_d = '0;
    case (state_d)
      S_FETCH: ctl_d.ir_load   = 1'b1;
      S_READ:  ctl_d.rf_read   = 1'b1;
      S_EXEC:  ctl_d.alu_start = 1'b1;
      S_MEM_WAIT: begin
        if (state == S_READ) begin
          ctl_d.mem_start = 1'b1;
          ctl_d.mem_we    = (op_d == ST);
        end
      end
      S_WRITE: begin
        ctl_d.rf_write  = writes_rf(op_d);
        ctl_d.wb_sel    = writes_rf(op_d) ? wb_src(op_d) : WB_ALU;
        ctl_d.wb_r1     = (op_d == BEQ);
        // r1_zero is only meaningful on the READ->WRITE edge of a BNZ.
        ctl_d.pc_branch = (op_d == BNZ) && !r1_zero;
        ctl_d.pc_inc    = !((op_d == BNZ) && !r1_zero);
      end
      default: ctl_d = '0;
    endcase
    ctl_d.busy = (state_d != S_IDLE) && (state_d != S_HALT);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      ctl_q     <= '0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state <= state_d;
      ctl_q <= ctl_d;
      if (state == S_FETCH) op_q <= instruction;
      if ((state == S_MEM_WAIT) && (state_d == S_HALT)) fault_q <= 1'b1;
      if (state == S_WRITE) retired_q <= retired_q + CNT_W'(1);
    end
  end

  nrisc_timeout_counter #(
    .LIMIT(MEM_TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (to_clear),
    .load    (to_load),
    .inc     (to_inc),
    .terminal(to_terminal)
  );

  assign ir_load   = ctl_q.ir_load;
  assign rf_read   = ctl_q.rf_read;
  assign alu_start = ctl_q.alu_start;
  assign mem_start = ctl_q.mem_start;
  assign mem_we    = ctl_q.mem_we;
  assign rf_write  = ctl_q.rf_write;
  assign wb_sel    = ctl_q.wb_sel;
  assign wb_r1     = ctl_q.wb_r1;
  assign pc_inc    = ctl_q.pc_inc;
  assign pc_branch = ctl_q.pc_branch;
  assign busy      = ctl_q.busy;
  assign fault     = fault_q;
  assign retired   = retired_q;

endmodule
